// File: rtl/clk_div_pkg.sv
// Shared types, constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUN     = 2'd1,
    ST_PEND    = 2'd2
  } ch_state_e;

  localparam int unsigned MIN_PERIOD = 2;

  function automatic int unsigned ch_w(input int unsigned channels);
    return (channels > 1) ? int'($clog2(channels)) : 1;
  endfunction

  function automatic int unsigned default_period(input int unsigned clk_freq,
                                                 input int unsigned out_freq);
    int unsigned p;
    p = (out_freq == 0) ? clk_freq : clk_freq / out_freq;
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

  function automatic int unsigned clamp_period(input int unsigned period);
    return (period < MIN_PERIOD) ? MIN_PERIOD : period;
  endfunction

  // Expects an already clamped period (>= MIN_PERIOD).
  function automatic int unsigned clamp_high(input int unsigned high,
                                             input int unsigned period);
    if (high == 0) return 1;
    if (high >= period) return period - 1;
    return high;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, STOPPED/RUN/PEND FSM, pending slot and registered outputs.
// CLK_DIV_DUTY_EN adds the i_high port and the per-channel high-time registers.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_WIDTH    = 28,
  parameter int unsigned RESET_PERIOD = 4
) (
  input  logic                 clk_in,
  input  logic                 aresetn,
  input  logic                 i_load,
  input  logic                 i_restart,
  input  logic [CNT_WIDTH-1:0] i_period,
`ifdef CLK_DIV_DUTY_EN
  input  logic [CNT_WIDTH-1:0] i_high,
`endif
  input  logic                 i_enable,
  output logic                 o_pend,
  output logic                 o_clk,
  output logic                 o_tick
);

  localparam logic [CNT_WIDTH-1:0] RST_PERIOD = CNT_WIDTH'(RESET_PERIOD);
  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

  ch_state_e            r_state, w_state_nxt;
  logic [CNT_WIDTH-1:0] r_count, w_count_nxt;
  logic [CNT_WIDTH-1:0] r_period, w_period_nxt;
  logic [CNT_WIDTH-1:0] r_pend_period, w_pend_period_nxt;
  logic                 r_pend_enable, w_pend_enable_nxt;
  logic                 r_clk, w_clk_nxt;
  logic                 r_tick, w_tick_nxt;
  logic [CNT_WIDTH-1:0] w_high, w_count_inc, w_src_period;
  logic                 w_src_enable, w_wrap;

`ifdef CLK_DIV_DUTY_EN
  logic [CNT_WIDTH-1:0] r_high, w_high_nxt;
  logic [CNT_WIDTH-1:0] r_pend_high, w_pend_high_nxt;
  logic [CNT_WIDTH-1:0] w_src_high;
  assign w_high = r_high;
`else
  assign w_high = r_period >> 1;
`endif

  assign w_wrap      = (r_count == r_period - ONE);
  assign w_count_inc = w_wrap ? '0 : r_count + ONE;

  // Values loaded at a boundary/restart: same-cycle config first, then pending slot, else current.
  always_comb begin
    w_src_period = r_period;
    w_src_enable = 1'b1;
`ifdef CLK_DIV_DUTY_EN
    w_src_high   = r_high;
`endif
    if (i_load) begin
      w_src_period = i_period;
      w_src_enable = i_enable;
`ifdef CLK_DIV_DUTY_EN
      w_src_high   = i_high;
`endif
    end else if (r_state == ST_PEND) begin
      w_src_period = r_pend_period;
      w_src_enable = r_pend_enable;
`ifdef CLK_DIV_DUTY_EN
      w_src_high   = r_pend_high;
`endif
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_count_nxt       = r_count;
    w_period_nxt      = r_period;
    w_pend_period_nxt = r_pend_period;
    w_pend_enable_nxt = r_pend_enable;
    w_clk_nxt         = 1'b0;
    w_tick_nxt        = 1'b0;
`ifdef CLK_DIV_DUTY_EN
    w_high_nxt        = r_high;
    w_pend_high_nxt   = r_pend_high;
`endif
    case (r_state)
      ST_RUN, ST_PEND: begin
        if (i_restart || (r_state == ST_PEND && w_wrap)) begin
          w_period_nxt = w_src_period;
`ifdef CLK_DIV_DUTY_EN
          w_high_nxt   = w_src_high;
`endif
          w_count_nxt  = '0;
          if (w_src_enable) begin
            // High time is always >= 1, so phase 0 is high.
            w_state_nxt = ST_RUN;
            w_clk_nxt   = 1'b1;
            w_tick_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_STOPPED;
          end
        end else begin
          w_count_nxt = w_count_inc;
          w_clk_nxt   = (w_count_inc < w_high);
          w_tick_nxt  = w_wrap;
          if (i_load) begin
            w_pend_period_nxt = i_period;
            w_pend_enable_nxt = i_enable;
`ifdef CLK_DIV_DUTY_EN
            w_pend_high_nxt   = i_high;
`endif
            w_state_nxt       = ST_PEND;
          end
        end
      end
      ST_STOPPED: begin
        if (i_load) begin
          w_period_nxt = i_period;
`ifdef CLK_DIV_DUTY_EN
          w_high_nxt   = i_high;
`endif
          if (i_enable) begin
            w_state_nxt = ST_RUN;
            w_count_nxt = '0;
            w_clk_nxt   = 1'b1;
            w_tick_nxt  = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= ST_RUN;
      r_count       <= '0;
      r_period      <= RST_PERIOD;
      r_pend_period <= RST_PERIOD;
      r_pend_enable <= 1'b1;
      r_clk         <= 1'b0;
      r_tick        <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
      r_high        <= RST_PERIOD >> 1;
      r_pend_high   <= RST_PERIOD >> 1;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_period      <= w_period_nxt;
      r_pend_period <= w_pend_period_nxt;
      r_pend_enable <= w_pend_enable_nxt;
      r_clk         <= w_clk_nxt;
      r_tick        <= w_tick_nxt;
`ifdef CLK_DIV_DUTY_EN
      r_high        <= w_high_nxt;
      r_pend_high   <= w_pend_high_nxt;
`endif
    end
  end

  assign o_pend = (r_state == ST_PEND);
  assign o_clk  = r_clk;
  assign o_tick = r_tick;

endmodule

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock/tick generator: config decode, clamping, cfg_ready and restart fan-out.
// Define CLK_DIV_DUTY_EN for the cfg_high port and programmable duty cycle.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter  int unsigned CHANNELS     = 4,
  parameter  int unsigned CNT_WIDTH    = 28,
  parameter  int unsigned I_CLK_FREQ   = 200_000_000,
  parameter  int unsigned DEFAULT_FREQ = 1,
  localparam int unsigned CH_W         = ch_w(CHANNELS)
) (
  input  logic                 clk_in,
  input  logic                 aresetn,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CH_W-1:0]      cfg_chan,
  input  logic [CNT_WIDTH-1:0] cfg_period,
`ifdef CLK_DIV_DUTY_EN
  input  logic [CNT_WIDTH-1:0] cfg_high,
`endif
  input  logic                 cfg_enable,
  input  logic                 sync_restart,
  output logic [CHANNELS-1:0]  clk_out,
  output logic [CHANNELS-1:0]  tick
);

  localparam int unsigned RESET_PERIOD = default_period(I_CLK_FREQ, DEFAULT_FREQ);

  logic                 w_accept;
  logic [CHANNELS-1:0]  w_load;
  logic [CHANNELS-1:0]  w_pend;
  logic [CNT_WIDTH-1:0] w_cfg_period;

  // Clamping happens once here so every channel captures legal values.
  assign w_cfg_period = CNT_WIDTH'(clamp_period(32'(cfg_period)));
`ifdef CLK_DIV_DUTY_EN
  logic [CNT_WIDTH-1:0] w_cfg_high;
  assign w_cfg_high = CNT_WIDTH'(clamp_high(32'(cfg_high), 32'(w_cfg_period)));
`endif

  assign w_accept  = cfg_valid && cfg_ready;
  assign cfg_ready = ~|w_pend;

  // Out-of-range channel numbers match no instance and are dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign w_load[g] = w_accept && (cfg_chan == CH_W'(g));

    clk_div_channel #(
      .CNT_WIDTH    (CNT_WIDTH),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_chan (
      .clk_in    (clk_in),
      .aresetn   (aresetn),
      .i_load    (w_load[g]),
      .i_restart (sync_restart),
      .i_period  (w_cfg_period),
`ifdef CLK_DIV_DUTY_EN
      .i_high    (w_cfg_high),
`endif
      .i_enable  (cfg_enable),
      .o_pend    (w_pend[g]),
      .o_clk     (clk_out[g]),
      .o_tick    (tick[g])
    );
  end

endmodule

// File: tb/tb_clk_divider_multi.sv
// Directed self-checking bench for clk_divider_multi (200-cycle-scale scenarios, 1000 Hz / 250 Hz default).
`timescale 1ns/1ps
module tb_clk_divider_multi;

  localparam int unsigned CHANNELS  = 4;
  localparam int unsigned CNT_WIDTH = 28;

  logic                 clk_in = 1'b0;
  logic                 aresetn = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic                 cfg_ready;
  logic [1:0]           cfg_chan = '0;
  logic [CNT_WIDTH-1:0] cfg_period = '0;
`ifdef CLK_DIV_DUTY_EN
  logic [CNT_WIDTH-1:0] cfg_high = '0;
`endif
  logic                 cfg_enable = 1'b0;
  logic                 sync_restart = 1'b0;
  logic [CHANNELS-1:0]  clk_out;
  logic [CHANNELS-1:0]  tick;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_in = ~clk_in;

  clk_divider_multi #(
    .CHANNELS     (CHANNELS),
    .CNT_WIDTH    (CNT_WIDTH),
    .I_CLK_FREQ   (1000),
    .DEFAULT_FREQ (250)
  ) dut (
    .clk_in       (clk_in),
    .aresetn      (aresetn),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_chan     (cfg_chan),
    .cfg_period   (cfg_period),
`ifdef CLK_DIV_DUTY_EN
    .cfg_high     (cfg_high),
`endif
    .cfg_enable   (cfg_enable),
    .sync_restart (sync_restart),
    .clk_out      (clk_out),
    .tick         (tick)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Presents one config for exactly one edge; caller guarantees cfg_ready is high.
  task automatic do_cfg(input logic [1:0] ch, input int unsigned p, input int unsigned h,
                        input logic en);
    cfg_valid  = 1'b1;
    cfg_chan   = ch;
    cfg_period = CNT_WIDTH'(p);
`ifdef CLK_DIV_DUTY_EN
    cfg_high   = CNT_WIDTH'(h);
`else
    if (h > 32'hFFFF_0000) cfg_period = CNT_WIDTH'(p);
`endif
    cfg_enable = en;
    step();
    cfg_valid  = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (cfg_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_clk;
    logic [7:0] exp_tick;
    exp_clk  = 8'b1001_1001;
    exp_tick = 8'b1000_1000;
    aresetn = 1'b0;
    step(); step(); step();
    n_checks++; if (clk_out !== 4'h0) begin n_fail++; $display("FAIL reset_clk: got %b expected 0000", clk_out); end
    n_checks++; if (tick !== 4'h0) begin n_fail++; $display("FAIL reset_tick: got %b expected 0000", tick); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cfg_ready); end
    aresetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (clk_out !== {4{exp_clk[i]}} || tick !== {4{exp_tick[i]}}) begin
        n_fail++;
        $display("FAIL default_pattern[%0d]: got clk=%b tick=%b expected clk=%b tick=%b",
                 i, clk_out, tick, {4{exp_clk[i]}}, {4{exp_tick[i]}});
      end
    end
  endtask

  task automatic test_reprogram();
    logic [11:0] exp_clk;
    logic [11:0] exp_tick;
    exp_clk  = 12'b0001_1100_0111;
    exp_tick = 12'b0000_0100_0001;
    step();
    do_cfg(2'd1, 6, 3, 1'b1);
    n_checks++; if ({cfg_ready, clk_out[1], tick[1]} !== 3'b000) begin n_fail++; $display("FAIL reprog_capture: got ready/clk/tick=%b expected 000", {cfg_ready, clk_out[1], tick[1]}); end
    step();
    n_checks++; if ({cfg_ready, clk_out[1], tick[1]} !== 3'b000) begin n_fail++; $display("FAIL reprog_hold: got ready/clk/tick=%b expected 000", {cfg_ready, clk_out[1], tick[1]}); end
    step();
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reprog_ready_back: got %b expected 1", cfg_ready); end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) step();
      n_checks++;
      if (clk_out[1] !== exp_clk[i] || tick[1] !== exp_tick[i]) begin
        n_fail++;
        $display("FAIL reprog_p6[%0d]: got clk=%b tick=%b expected clk=%b tick=%b",
                 i, clk_out[1], tick[1], exp_clk[i], exp_tick[i]);
      end
    end
  endtask

  task automatic test_duty();
    int unsigned p_tab[3];
    int unsigned h_tab[3];
    int unsigned eff_p[3];
    logic [9:0]  pat[3];
    bit          ok;
`ifdef CLK_DIV_DUTY_EN
    p_tab = '{5, 5, 0}; h_tab = '{0, 9, 0}; eff_p = '{5, 5, 2};
    pat   = '{10'b00001_00001, 10'b01111_01111, 10'b01010_10101};
`else
    p_tab = '{5, 6, 0}; h_tab = '{0, 0, 0}; eff_p = '{5, 6, 2};
    pat   = '{10'b00011_00011, 10'b01110_00111, 10'b01010_10101};
`endif
    for (int c = 0; c < 3; c++) begin
      do_cfg(2'd0, p_tab[c], h_tab[c], 1'b1);
      wait_ready(ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL duty_wait[%0d]: got timeout expected cfg_ready", c); end
      for (int i = 0; i < 10; i++) begin
        if (i > 0) step();
        n_checks++;
        if (clk_out[0] !== pat[c][i] || tick[0] !== ((i % eff_p[c]) == 0)) begin
          n_fail++;
          $display("FAIL duty[%0d][%0d]: got clk=%b tick=%b expected clk=%b tick=%b",
                   c, i, clk_out[0], tick[0], pat[c][i], ((i % eff_p[c]) == 0));
        end
      end
    end
  endtask

  task automatic test_disable();
    logic [5:0] exp_clk;
    logic [5:0] exp_tick;
    bit         ok;
`ifdef CLK_DIV_DUTY_EN
    exp_clk = 6'b011_011;
`else
    exp_clk = 6'b001_001;
`endif
    exp_tick = 6'b001_001;
    do_cfg(2'd2, 4, 2, 1'b0);
    wait_ready(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL disable_wait: got timeout expected cfg_ready"); end
    for (int i = 0; i < 8; i++) begin
      if (i > 0) step();
      n_checks++;
      if ({clk_out[2], tick[2]} !== 2'b00) begin
        n_fail++;
        $display("FAIL stopped[%0d]: got clk/tick=%b expected 00", i, {clk_out[2], tick[2]});
      end
    end
    do_cfg(2'd2, 3, 2, 1'b1);
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reenable_ready: got %b expected 1", cfg_ready); end
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      n_checks++;
      if (clk_out[2] !== exp_clk[i] || tick[2] !== exp_tick[i]) begin
        n_fail++;
        $display("FAIL reenable[%0d]: got clk=%b tick=%b expected clk=%b tick=%b",
                 i, clk_out[2], tick[2], exp_clk[i], exp_tick[i]);
      end
    end
  endtask

  task automatic test_sync_restart();
    bit ok;
    do_cfg(2'd0, 4, 2, 1'b1);
    wait_ready(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sync_wait: got timeout expected cfg_ready"); end
    step(); step(); step();
    // ch3 config accepted in the restart cycle is applied by the restart itself.
    cfg_valid    = 1'b1;
    cfg_chan     = 2'd3;
    cfg_period   = CNT_WIDTH'(7);
`ifdef CLK_DIV_DUTY_EN
    cfg_high     = CNT_WIDTH'(3);
`endif
    cfg_enable   = 1'b1;
    sync_restart = 1'b1;
    step();
    cfg_valid    = 1'b0;
    sync_restart = 1'b0;
    n_checks++; if (tick !== 4'hF || clk_out !== 4'hF) begin n_fail++; $display("FAIL sync_align: got clk=%b tick=%b expected clk=1111 tick=1111", clk_out, tick); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL sync_ready: got %b expected 1", cfg_ready); end
    for (int i = 1; i <= 28; i++) begin
      step();
      n_checks++;
      if ((tick[0] & tick[3]) !== ((i % 28) == 0) || clk_out[3] !== ((i % 7) < 3) ||
          clk_out[0] !== ((i % 4) < 2)) begin
        n_fail++;
        $display("FAIL sync_phase[%0d]: got tick0&3=%b clk0=%b clk3=%b expected %b %b %b", i,
                 tick[0] & tick[3], clk_out[0], clk_out[3], ((i % 28) == 0), ((i % 4) < 2), ((i % 7) < 3));
      end
    end
  endtask

  task automatic test_restart_pend();
    do_cfg(2'd1, 100, 50, 1'b1);
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rpend_capture: got %b expected 0", cfg_ready); end
    sync_restart = 1'b1;
    step();
    sync_restart = 1'b0;
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rpend_ready: got %b expected 1", cfg_ready); end
    n_checks++; if (tick !== 4'hF || clk_out[1] !== 1'b1) begin n_fail++; $display("FAIL rpend_align: got tick=%b clk1=%b expected 1111 1", tick, clk_out[1]); end
    for (int i = 1; i <= 51; i++) begin
      step();
      n_checks++;
      if (clk_out[1] !== (i < 50)) begin
        n_fail++;
        $display("FAIL rpend_p100[%0d]: got clk=%b expected %b", i, clk_out[1], (i < 50));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp_clk;
    logic [7:0] exp_tick;
    exp_clk  = 8'b1001_1001;
    exp_tick = 8'b1000_1000;
    do_cfg(2'd1, 10, 5, 1'b1);
    n_checks++; if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_pend: got %b expected 0", cfg_ready); end
    #2 aresetn = 1'b0;
    #1;
    n_checks++; if (clk_out !== 4'h0 || tick !== 4'h0) begin n_fail++; $display("FAIL rmid_async: got clk=%b tick=%b expected 0000 0000", clk_out, tick); end
    n_checks++; if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b expected 1", cfg_ready); end
    step(); step();
    aresetn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (clk_out !== {4{exp_clk[i]}} || tick !== {4{exp_tick[i]}} || cfg_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL rmid_default[%0d]: got clk=%b tick=%b ready=%b expected clk=%b tick=%b ready=1",
                 i, clk_out, tick, cfg_ready, {4{exp_clk[i]}}, {4{exp_tick[i]}});
      end
    end
  endtask

  initial begin
    test_reset();
    test_reprogram();
    test_duty();
    test_disable();
    test_sync_restart();
    test_restart_pend();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: got no completion expected finish before 200us");
    $fatal(1, "watchdog");
  end

endmodule
